// File: rtl/fcbt_pkg.sv
// rtl/fcbt_pkg.sv - shared defaults, entry type and count-width helper for the FCBT result buffer
package fcbt_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int GID_WIDTH_DEF = 16;

    typedef struct packed {
        logic [GID_WIDTH_DEF-1:0] gid;
        logic [WIDTH_DEF-1:0]     data;
    } rb_entry_t;

    // Occupancy needs one bit more than the address so that DEPTH itself is representable
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fcbt_rb_fifo.sv
// rtl/fcbt_rb_fifo.sv - result buffer storage: synchronous write, registered read port
module fcbt_rb_fifo #(
    parameter int DW    = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DW-1:0]            rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register only updates on rd_en_i, so it holds the last head while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fcbt_result_buffer.sv
// rtl/fcbt_result_buffer.sv - gid-tagging result FIFO with hold backpressure; FCBT_RB_STATS_EN adds max_count/drop_count
module fcbt_result_buffer
    import fcbt_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = 16,
    parameter int HOLD_MARGIN = 2,
    parameter int GID_WIDTH   = GID_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          acc_result,
    input  logic                      acc_valid,
    output logic                      hold_output,
    output logic [WIDTH-1:0]          out_data,
    output logic [GID_WIDTH-1:0]      out_gid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      overflow
`ifdef FCBT_RB_STATS_EN
    ,
    output logic [count_w(DEPTH)-1:0] max_count,
    output logic [15:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam int EW = GID_WIDTH + WIDTH;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LVL = CW'(DEPTH - HOLD_MARGIN);

    // Pointers carry a wrap bit, so their difference is the occupancy directly
    logic [CW-1:0]        wptr_q, wptr_d;
    logic [CW-1:0]        rptr_q, rptr_d;
    logic [GID_WIDTH-1:0] gid_q, gid_d;
    logic                 valid_q, valid_d;
    logic                 hold_q, hold_d;
    logic                 ovf_q, ovf_d;

    logic [CW-1:0] occ;
    logic [CW-1:0] occ_d;
    logic          pop;
    logic          push;
    logic          drop;
    logic          load_head;
    logic [EW-1:0] head_entry;

    always_comb begin
        occ       = wptr_q - rptr_q;
        pop       = valid_q && out_ready;
        push      = acc_valid && ((occ != FULL_LVL) || pop);
        drop      = acc_valid && !push;
        // Head is only fetched from slots written at an earlier edge: no fall-through
        load_head = !valid_q && (occ != '0);
        wptr_d    = wptr_q + CW'(push);
        rptr_d    = rptr_q + CW'(pop);
        occ_d     = wptr_d - rptr_d;
        gid_d     = gid_q + GID_WIDTH'(acc_valid);
        valid_d   = load_head || (valid_q && !pop);
        hold_d    = (occ_d >= HOLD_LVL);
        ovf_d     = ovf_q || drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            gid_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            gid_q   <= gid_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    fcbt_rb_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (push),
        .wr_addr_i (wptr_q[AW-1:0]),
        .wr_data_i ({gid_q, acc_result}),
        .rd_en_i   (load_head),
        .rd_addr_i (rptr_q[AW-1:0]),
        .rd_data_o (head_entry)
    );

    assign {out_gid, out_data} = head_entry;
    assign out_valid           = valid_q;
    assign count               = occ;
    assign hold_output         = hold_q;
    assign overflow            = ovf_q;

`ifdef FCBT_RB_STATS_EN
    logic [CW-1:0] max_q, max_d;
    logic [15:0]   drops_q, drops_d;

    always_comb begin
        max_d   = (occ_d > max_q) ? occ_d : max_q;
        drops_d = (drop && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q   <= '0;
            drops_q <= '0;
        end else begin
            max_q   <= max_d;
            drops_q <= drops_d;
        end
    end

    assign max_count  = max_q;
    assign drop_count = drops_q;
`endif

endmodule

// File: tb/tb_fcbt_result_buffer.sv
// tb/tb_fcbt_result_buffer.sv - scoreboard bench for fcbt_result_buffer (covers FCBT_RB_STATS_EN when defined)
module tb_fcbt_result_buffer;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int HM = 2;
    localparam int GW = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          rst;
    logic [W-1:0]  acc_result;
    logic          acc_valid;
    logic          hold_output;
    logic [W-1:0]  out_data;
    logic [GW-1:0] out_gid;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef FCBT_RB_STATS_EN
    logic [CW-1:0] max_count;
    logic [15:0]   drop_count;
`endif

    fcbt_result_buffer #(
        .WIDTH       (W),
        .DEPTH       (D),
        .HOLD_MARGIN (HM),
        .GID_WIDTH   (GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_result  (acc_result),
        .acc_valid   (acc_valid),
        .hold_output (hold_output),
        .out_data    (out_data),
        .out_gid     (out_gid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow)
`ifdef FCBT_RB_STATS_EN
        ,
        .max_count   (max_count),
        .drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: ordered list of accepted {gid,data}; FIFO occupancy is its size
    logic [GW+W-1:0] exp_q[$];
    logic [GW-1:0]   gid_m;
    logic            ovf_m;
    int              max_m;
    int              drop_m;
    logic            pop_s;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                gid_m  = '0;
                ovf_m  = 1'b0;
                max_m  = 0;
                drop_m = 0;
            end else begin
                check("count", 64'(count), 64'(exp_q.size()));
                check("overflow", 64'(overflow), 64'(ovf_m));
                check("hold", 64'(hold_output), 64'((D - exp_q.size()) <= HM));
`ifdef FCBT_RB_STATS_EN
                check("max_count", 64'(max_count), 64'(max_m));
                check("drop_count", 64'(drop_count), 64'(drop_m));
`endif
                if (out_valid && exp_q.size() == 0)
                    check("out_valid_empty", 64'(out_valid), 64'(0));
                pop_s = out_valid && out_ready && (exp_q.size() != 0);
                if (pop_s) begin
                    check("head", 64'({out_gid, out_data}), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (acc_valid) begin
                    if (exp_q.size() < D) begin
                        exp_q.push_back({gid_m, acc_result});
                    end else begin
                        ovf_m = 1'b1;
                        if (drop_m < 65535) drop_m++;
                    end
                    gid_m = gid_m + 1'b1;
                end
                if (exp_q.size() > max_m) max_m = exp_q.size();
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        acc_valid  = v;
        acc_result = d;
        out_ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_gid", 64'(out_gid), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_hold", 64'(hold_output), 64'(0));
        rst = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (count != 0 && n < 100) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_count", 64'(count), 64'(0));
        step(1'b0, '0, 1'b1);
        check("drain_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        rst        = 1'b0;
        acc_valid  = 1'b0;
        acc_result = '0;
        out_ready  = 1'b0;
        do_reset();

        // single push: registered head appears one cycle after the push edge, for one cycle
        step(1'b1, 32'h42C8_0000, 1'b1);
        check("single_lat", 64'(out_valid), 64'(0));
        step(1'b0, '0, 1'b1);
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_data", 64'(out_data), 64'h42C8_0000);
        check("single_gid", 64'(out_gid), 64'(0));
        step(1'b0, '0, 1'b1);
        check("single_once", 64'(out_valid), 64'(0));

        // backpressure threshold and fill to full
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, $urandom, 1'b0);
            if (i == 12) check("hold_at_13", 64'(hold_output), 64'(0));
        end
        check("hold_at_14", 64'(hold_output), 64'(1));
        check("count_14", 64'(count), 64'(14));
        step(1'b1, $urandom, 1'b0);
        step(1'b1, $urandom, 1'b0);
        check("count_16", 64'(count), 64'(16));
        check("full_no_ovf", 64'(overflow), 64'(0));

        // overflow: dropped sum still consumes a gid
        step(1'b1, 32'h3F80_0000, 1'b0);
        check("ovf_set", 64'(overflow), 64'(1));
        check("ovf_count", 64'(count), 64'(16));
        drain();
        check("ovf_sticky", 64'(overflow), 64'(1));
        step(1'b1, 32'h1234_5678, 1'b0);
        step(1'b0, '0, 1'b0);
        check("gap_valid", 64'(out_valid), 64'(1));
        check("gap_gid", 64'(out_gid), 64'(17 % (1 << GW)));
        drain();

        // full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 1'b1);
        check("fs_count", 64'(count), 64'(16));
        check("fs_ovf", 64'(overflow), 64'(0));
        drain();

        // gid and pointer wrap under continuous push/pop
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1);
        drain();

        // randomized traffic including overflow episodes
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 40);
        drain();

        // asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA5A5_0000 | 32'(i + 1), 1'b0);
        check("ar_count5", 64'(count), 64'(5));
        #2;
        rst       = 1'b0;
        acc_valid = 1'b0;
        #1;
        check("ar_count", 64'(count), 64'(0));
        check("ar_valid", 64'(out_valid), 64'(0));
        check("ar_data", 64'(out_data), 64'(0));
        check("ar_gid", 64'(out_gid), 64'(0));
        check("ar_ovf", 64'(overflow), 64'(0));
        check("ar_hold", 64'(hold_output), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 32'h4049_0FDB, 1'b0);
        step(1'b0, '0, 1'b0);
        check("ar_next_valid", 64'(out_valid), 64'(1));
        check("ar_next_gid", 64'(out_gid), 64'(0));
        check("ar_next_data", 64'(out_data), 64'h4049_0FDB);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fcbt_result_buffer.md
Name: fcbt_result_buffer

Overview:
- Downstream stage of the FCBT accumulator wrapper: captures each per-group sum (IEEE-754 single-precision bits) when the accumulator pulses valid_out.
- Tags each sum with a sequential group ID and buffers it in a FIFO.
- Presents entries to a consumer over a valid/ready handshake.
- Drives the accumulator's hold_output input for backpressure, with headroom for sums already in flight.

Parameters:
- WIDTH, 32, result word width (float bits, passed through unchanged).
- DEPTH, 16, FIFO entries; power of two, at least 4.
- HOLD_MARGIN, 2, free entries kept in reserve; hold_output asserts when free entries <= HOLD_MARGIN.
- GID_WIDTH, 16, width of the group ID tag; wraps modulo 2^GID_WIDTH.

Ports:
- clk, input, 1, clock (rising edge).
- rst, input, 1, reset; asynchronous, active-low (0 = reset).
- acc_result, input, WIDTH, sum from the accumulator.
- acc_valid, input, 1, one-cycle strobe: acc_result is valid.
- hold_output, output, 1, backpressure to the accumulator.
- out_data, output, WIDTH, head-of-FIFO sum.
- out_gid, output, GID_WIDTH, group ID of out_data.
- out_valid, output, 1, head entry is valid.
- out_ready, input, 1, consumer accepts the head this cycle.
- count, output, $clog2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky: a sum was dropped.

Behaviour:
- Reset (rst low, asynchronous): the FIFO is emptied and the following are zero: count, out_valid, out_data, out_gid, overflow, hold_output, and the gid counter.
- Push:
  - Occurs when acc_valid=1 and (count<DEPTH, or a pop happens in the same cycle).
  - The entry stores {gid_counter, acc_result}; gid_counter then increments, wrapping 2^GID_WIDTH-1 -> 0.
- Pop:
  - Occurs when out_valid=1 and out_ready=1 at a rising edge; the head advances.
  - out_data and out_gid are stable while out_valid=1 and out_ready=0.
- Latency:
  - The output is registered; no fall-through.
  - A push into an empty FIFO at edge N gives out_valid=1 after edge N+1.
  - A sum pushed at edge N becomes the visible head one cycle after it reaches the front.
- Simultaneous push and pop:
  - count stays the same.
  - When full, both occur: the head leaves, the new entry lands at the tail, and there is no overflow.
- Full: acc_valid=1 with count==DEPTH and no pop:
  - The sum is dropped and the gid counter still increments, so the lost group stays visible as a gid gap.
  - overflow is set and stays set until reset.
- Empty: out_valid=0; out_ready is ignored; out_data and out_gid hold their last values.
- hold_output:
  - Registered; hold_output = (DEPTH - next_count) <= HOLD_MARGIN.
  - It is asserted the cycle after the threshold is crossed and deasserted the cycle after space frees up.
  - The upstream may still deliver up to HOLD_MARGIN sums after assertion.
- Pointers: read and write pointers carry an extra wrap bit, so full and empty are distinguished by the wrap bit.
- Reset mid-operation: all contents are discarded immediately; the in-flight acc_valid at the reset edge is lost.
- No state machine beyond the FIFO control.

Optional Feature:
- Macro: FCBT_RB_STATS_EN.
- Defined:
  - Adds output max_count (same width as count): the high-water mark of occupancy.
  - Adds output drop_count (16 bits): saturating count of dropped sums.
  - Both are cleared by reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package fcbt_pkg holds:
  - the WIDTH default and GID_WIDTH default;
  - typedef rb_entry_t as a packed struct {gid, data};
  - function clog2-based COUNT_W.
- One sub-module, fcbt_rb_fifo: synchronous-write storage with a registered read port.
- fcbt_result_buffer keeps the pointers, count, hold, overflow and gid logic.

Test Plan:
- Single push:
  - Stimulus: reset, then acc_valid for 1 cycle with acc_result = 0x42C80000 (100.0); out_ready=1.
  - Response: out_valid=1 for exactly one cycle, one cycle after the push edge; out_data=0x42C80000, out_gid=0.
- Backpressure:
  - Stimulus: out_ready=0; push 14 sums with DEPTH=16 and HOLD_MARGIN=2.
  - Response: hold_output=1 the cycle after the 14th push; count=14; push 2 more -> count=16, overflow=0.
- Overflow:
  - Stimulus: while full, one more acc_valid with acc_result=0x3F800000.
  - Response: overflow=1, count=16; after draining all 16 entries, the gids read are 0..15 and the next push gets gid 17.
- Full simultaneous:
  - Stimulus: count=16; acc_valid=1 and out_ready=1 in the same cycle.
  - Response: count stays 16, overflow=0, the new entry appears last.
- Wrap:
  - Stimulus: GID_WIDTH=4; push and pop 20 sums.
  - Response: out_gid sequence is 0..15,0..3; pointers wrap with no data corruption.
- Async reset:
  - Stimulus: assert rst low mid-cycle with count=5.
  - Response: outputs are zero before the next edge; after release the next push gets gid 0.
